can_destuff: RTL and testbench
==============================

Name: can_destuff

Overview:
Bit-level CAN receive stage between the bit-timing/sampling logic and the CRC-15 checker.
- Consumes one sampled bus bit per sample strobe.
- Detects bus idle and start-of-frame.
- Removes stuff bits and flags stuff errors.
- Emits a strobed destuffed bit stream; downstream CRC and field decoder advance only on dout_valid.

Parameters:
STUFF_LEN, 5, consecutive equal bits after which the next bit is a stuff bit
IDLE_LEN, 11, consecutive recessive bits that declare bus idle (ACK delimiter + EOF + intermission)

Ports:
clk  input  1  system clock; all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
sample_valid  input  1  single-cycle strobe at the bit sample point
rx_bit  input  1  sampled bus level, 1 = recessive; qualified by sample_valid
stuff_en  input  1  from frame decoder; high from SOF through the last CRC bit
dout  output  1  destuffed bit; valid only with dout_valid
dout_valid  output  1  one-cycle strobe per destuffed bit
stuff_bit  output  1  one-cycle pulse when a stuff bit is removed
stuff_err  output  1  one-cycle pulse on a stuff violation
sof  output  1  one-cycle pulse coincident with the SOF bit on dout_valid
bus_idle  output  1  level; high while in IDLE state

Behaviour:
- Reset (async, rst_n low):
  - state=WAIT_IDLE; run_cnt=0; idle_cnt=0; last_bit=1.
  - dout, dout_valid, stuff_bit, stuff_err, sof, bus_idle all 0.
- All outputs registered. Pulses assert the cycle after the qualifying sample_valid and last exactly one cycle.
- No action on cycles without sample_valid: all state held, pulses 0.
- WAIT_IDLE:
  - rx_bit=1 -> idle_cnt++.
  - rx_bit=0 -> idle_cnt=0.
  - When idle_cnt reaches IDLE_LEN -> IDLE, bus_idle=1.
  - No dout_valid in this state.
- IDLE:
  - rx_bit=1 -> stay.
  - rx_bit=0 -> SOF: dout=0, dout_valid=1, sof=1, bus_idle=0, last_bit=0, run_cnt=1, idle_cnt=0 -> FRAME.
- FRAME, evaluated in priority order per sample:
  1. Stuff slot (run_cnt==STUFF_LEN). This applies regardless of stuff_en, so the stuff bit following the last CRC bit is still removed.
     - rx_bit!=last_bit: stuff_bit=1, no dout_valid, last_bit=rx_bit, run_cnt=1.
     - rx_bit==last_bit: stuff_err=1, no dout_valid, idle_cnt=0 -> WAIT_IDLE.
  2. Otherwise, if stuff_en=1:
     - dout=rx_bit, dout_valid=1.
     - rx_bit==last_bit -> run_cnt++; else run_cnt=1, last_bit=rx_bit.
  3. Otherwise (stuff_en=0, fixed-form fields): pass-through.
     - dout=rx_bit, dout_valid=1, run_cnt=0.
     - rx_bit=1 -> idle_cnt++; rx_bit=0 -> idle_cnt=0.
     - When idle_cnt reaches IDLE_LEN -> IDLE, bus_idle=1, with no dout_valid for that terminating bit.
- Widths:
  - run_cnt is $clog2(STUFF_LEN+1) bits.
  - idle_cnt is $clog2(IDLE_LEN+1) bits and saturates at IDLE_LEN.
- Simultaneous events: stuff_err overrides every other output for that sample. sof and stuff_err never coincide.
- Reset mid-frame: immediate abort. The block must observe IDLE_LEN recessive bits again before accepting a new SOF.
- Error frames, overload frames and resynchronisation are out of scope. A stuff_err leaves the block waiting for idle.

Decomposition:
- Shared package can_pkg holds:
  - the state enum (WAIT_IDLE, IDLE, FRAME);
  - constants CAN_STUFF_LEN=5 and CAN_IDLE_LEN=11;
  - the recessive/dominant level constants.
- Single module, no sub-module. The run and idle counters are too small to justify separation.

Test Plan:
- Reset, then 11 samples of rx_bit=1 -> bus_idle rises the cycle after the 11th sample; 10 samples only -> bus_idle stays 0.
- Idle, then stuff_en=1 and bits 0,0,0,0,0,1,1 -> five dout_valid with dout=0 (first with sof=1); the sixth bit (1) gives stuff_bit=1 and no dout_valid; the seventh gives dout=1.
- FRAME, stuff_en=1, six consecutive 1s -> five dout_valid, then stuff_err=1 on the sixth, bus_idle=0, state WAIT_IDLE; a following dominant bit produces no sof.
- Five equal CRC bits with stuff_en falling before the next sample -> the next opposite bit is removed (stuff_bit=1), and subsequent bits pass through unstuffed with seven 1s giving no stuff_err.
- stuff_en=0 after CRC: bits 1,0 (ACK), then eleven 1s -> all passed with dout_valid except the 11th recessive, then bus_idle=1; sparse sample_valid (gaps of 3 idle clocks) gives an identical result.
- rst_n pulled low mid-frame asynchronously -> outputs clear without a clock edge; after release, a dominant bit gives no sof until 11 recessive bits are seen.

Source files
------------

// File: rtl/can_destuff_pkg.sv
// Shared definitions for the CAN receive destuffing stage: controller states,
// bit-stuffing / idle-detection lengths and bus level encodings.
package can_pkg;

    typedef enum logic [1:0] {
        WAIT_IDLE = 2'd0,
        IDLE      = 2'd1,
        FRAME     = 2'd2
    } can_state_t;

    localparam int CAN_STUFF_LEN = 5;
    localparam int CAN_IDLE_LEN  = 11;

    localparam logic RECESSIVE = 1'b1;
    localparam logic DOMINANT  = 1'b0;

endpackage

// File: rtl/can_destuff.sv
// CAN receive destuffer: finds bus idle and SOF, strips stuff bits, flags stuff
// violations and emits a strobed destuffed bit stream for the CRC/field decoder.
module can_destuff
    import can_pkg::*;
#(
    parameter int STUFF_LEN = CAN_STUFF_LEN,
    parameter int IDLE_LEN  = CAN_IDLE_LEN
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sample_valid,
    input  logic rx_bit,
    input  logic stuff_en,
    output logic dout,
    output logic dout_valid,
    output logic stuff_bit,
    output logic stuff_err,
    output logic sof,
    output logic bus_idle
);

    localparam int RW = $clog2(STUFF_LEN + 1);
    localparam int IW = $clog2(IDLE_LEN + 1);
    localparam logic [RW-1:0] RUN_ZERO = RW'(0);
    localparam logic [RW-1:0] RUN_ONE  = RW'(1);
    localparam logic [RW-1:0] RUN_MAX  = RW'(STUFF_LEN);
    localparam logic [IW-1:0] IDLE_ZERO = IW'(0);
    localparam logic [IW-1:0] IDLE_ONE  = IW'(1);
    localparam logic [IW-1:0] IDLE_MAX  = IW'(IDLE_LEN);

    can_state_t    state_r, state_s;
    logic [RW-1:0] run_cnt_r, run_cnt_s;
    logic [IW-1:0] idle_cnt_r, idle_cnt_s, idle_inc_s;
    logic          last_bit_r, last_bit_s;
    logic          dout_s, dout_valid_s, stuff_bit_s, stuff_err_s, sof_s;

    // Next-state and next-output decode, evaluated only on sample strobes.
    always_comb begin
        state_s      = state_r;
        run_cnt_s    = run_cnt_r;
        idle_cnt_s   = idle_cnt_r;
        last_bit_s   = last_bit_r;
        dout_s       = dout;
        dout_valid_s = 1'b0;
        stuff_bit_s  = 1'b0;
        stuff_err_s  = 1'b0;
        sof_s        = 1'b0;
        idle_inc_s   = (idle_cnt_r == IDLE_MAX) ? IDLE_MAX : (idle_cnt_r + IDLE_ONE);

        if (sample_valid) begin
            case (state_r)
                WAIT_IDLE: begin
                    if (rx_bit == RECESSIVE) begin
                        idle_cnt_s = idle_inc_s;
                        if (idle_inc_s == IDLE_MAX) begin
                            state_s = IDLE;
                        end else begin
                            state_s = WAIT_IDLE;
                        end
                    end else begin
                        idle_cnt_s = IDLE_ZERO;
                    end
                end
                IDLE: begin
                    if (rx_bit == DOMINANT) begin
                        dout_s       = DOMINANT;
                        dout_valid_s = 1'b1;
                        sof_s        = 1'b1;
                        last_bit_s   = DOMINANT;
                        run_cnt_s    = RUN_ONE;
                        idle_cnt_s   = IDLE_ZERO;
                        state_s      = FRAME;
                    end else begin
                        state_s = IDLE;
                    end
                end
                FRAME: begin
                    // The stuff slot wins even after stuff_en drops, so the
                    // stuff bit trailing the last CRC bit is still removed.
                    if (run_cnt_r == RUN_MAX) begin
                        if (rx_bit != last_bit_r) begin
                            stuff_bit_s = 1'b1;
                            last_bit_s  = rx_bit;
                            run_cnt_s   = RUN_ONE;
                        end else begin
                            stuff_err_s = 1'b1;
                            idle_cnt_s  = IDLE_ZERO;
                            state_s     = WAIT_IDLE;
                        end
                    end else if (stuff_en) begin
                        dout_s       = rx_bit;
                        dout_valid_s = 1'b1;
                        if (rx_bit == last_bit_r) begin
                            run_cnt_s = run_cnt_r + RUN_ONE;
                        end else begin
                            run_cnt_s  = RUN_ONE;
                            last_bit_s = rx_bit;
                        end
                    end else begin
                        run_cnt_s = RUN_ZERO;
                        if ((rx_bit == RECESSIVE) && (idle_inc_s == IDLE_MAX)) begin
                            idle_cnt_s = idle_inc_s;
                            state_s    = IDLE;
                        end else if (rx_bit == RECESSIVE) begin
                            idle_cnt_s   = idle_inc_s;
                            dout_s       = rx_bit;
                            dout_valid_s = 1'b1;
                        end else begin
                            idle_cnt_s   = IDLE_ZERO;
                            dout_s       = rx_bit;
                            dout_valid_s = 1'b1;
                        end
                    end
                end
                default: begin
                    state_s    = WAIT_IDLE;
                    idle_cnt_s = IDLE_ZERO;
                end
            endcase
        end else begin
            state_s = state_r;
        end
    end

    // Controller state and counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= WAIT_IDLE;
            run_cnt_r  <= RUN_ZERO;
            idle_cnt_r <= IDLE_ZERO;
            last_bit_r <= RECESSIVE;
        end else begin
            state_r    <= state_s;
            run_cnt_r  <= run_cnt_s;
            idle_cnt_r <= idle_cnt_s;
            last_bit_r <= last_bit_s;
        end
    end

    // Registered outputs; pulses are single-cycle because their next value defaults low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout       <= 1'b0;
            dout_valid <= 1'b0;
            stuff_bit  <= 1'b0;
            stuff_err  <= 1'b0;
            sof        <= 1'b0;
            bus_idle   <= 1'b0;
        end else begin
            dout       <= dout_s;
            dout_valid <= dout_valid_s;
            stuff_bit  <= stuff_bit_s;
            stuff_err  <= stuff_err_s;
            sof        <= sof_s;
            bus_idle   <= (state_s == IDLE);
        end
    end

endmodule

// File: tb/tb_can_destuff.sv
// Self-checking bench for can_destuff: directed scenarios plus random frames,
// compared against a bit-history reference model of CAN destuffing.
module tb_can_destuff;

    logic clk = 1'b0;
    logic rst_n, sample_valid, rx_bit, stuff_en;
    logic dout, dout_valid, stuff_bit, stuff_err, sof, bus_idle;

    int checks = 0;
    int errors = 0;

    // Reference model: phase 0 waiting for idle, 1 idle, 2 in frame.
    int   m_phase;
    int   m_ones;      // trailing recessive bits seen (unbounded)
    logic m_hist[$];   // current run of identical stuffed-region bits

    can_destuff dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .sample_valid (sample_valid),
        .rx_bit       (rx_bit),
        .stuff_en     (stuff_en),
        .dout         (dout),
        .dout_valid   (dout_valid),
        .stuff_bit    (stuff_bit),
        .stuff_err    (stuff_err),
        .sof          (sof),
        .bus_idle     (bus_idle)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_phase = 0;
        m_ones  = 0;
        m_hist.delete();
    endtask

    task automatic model_step(input logic b, input logic en,
                              output logic e_dv, output logic e_dout,
                              output logic e_st, output logic e_err, output logic e_sof);
        e_dv = 1'b0; e_dout = b; e_st = 1'b0; e_err = 1'b0; e_sof = 1'b0;
        if (m_phase == 0) begin
            m_ones = b ? m_ones + 1 : 0;
            if (m_ones >= 11) m_phase = 1;
        end else if (m_phase == 1) begin
            if (!b) begin
                e_dv = 1'b1; e_sof = 1'b1;
                m_phase = 2; m_ones = 0;
                m_hist.delete(); m_hist.push_back(1'b0);
            end
        end else begin
            if (m_hist.size() == 5) begin
                if (b != m_hist[0]) begin
                    e_st = 1'b1;
                    m_hist.delete(); m_hist.push_back(b);
                end else begin
                    e_err = 1'b1;
                    m_phase = 0; m_ones = 0;
                end
            end else if (en) begin
                e_dv = 1'b1;
                if (m_hist.size() > 0 && b != m_hist[0]) m_hist.delete();
                m_hist.push_back(b);
            end else begin
                m_hist.delete();
                m_ones = b ? m_ones + 1 : 0;
                if (m_ones >= 11) m_phase = 1;
                else e_dv = 1'b1;
            end
        end
    endtask

    // Called at a falling edge; presents one sample and checks the registered response.
    task automatic send(input logic b, input logic en, input int gap);
        logic e_dv, e_dout, e_st, e_err, e_sof;
        sample_valid = 1'b1; rx_bit = b; stuff_en = en;
        model_step(b, en, e_dv, e_dout, e_st, e_err, e_sof);
        @(negedge clk);
        sample_valid = 1'b0;
        check("dout_valid", dout_valid, e_dv);
        check("stuff_bit", stuff_bit, e_st);
        check("stuff_err", stuff_err, e_err);
        check("sof", sof, e_sof);
        check("bus_idle", bus_idle, (m_phase == 1) ? 1'b1 : 1'b0);
        if (e_dv) check("dout", dout, e_dout);
        for (int g = 0; g < gap; g++) begin
            @(negedge clk);
            check("gap_valid", dout_valid, 1'b0);
            check("gap_pulse", stuff_bit | stuff_err | sof, 1'b0);
            check("gap_idle", bus_idle, (m_phase == 1) ? 1'b1 : 1'b0);
        end
    endtask

    task automatic send_run(input logic b, input logic en, input int n, input int gap);
        for (int k = 0; k < n; k++) send(b, en, gap);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_dout"}, dout, 1'b0);
        check({tag, "_valid"}, dout_valid, 1'b0);
        check({tag, "_stuff"}, stuff_bit, 1'b0);
        check({tag, "_err"}, stuff_err, 1'b0);
        check({tag, "_sof"}, sof, 1'b0);
        check({tag, "_idle"}, bus_idle, 1'b0);
    endtask

    // Tail of a frame: CRC run of five 0s, trailing stuff bit, pass-through, ACK, EOF.
    task automatic crc_tail_frame(input int gap);
        send(1'b0, 1'b1, gap);              // SOF
        send_run(1'b0, 1'b1, 4, gap);       // run of five dominant incl. SOF
        send(1'b1, 1'b0, gap);              // stuff bit after stuff_en fell
        send_run(1'b1, 1'b0, 7, gap);       // seven 1s, no stuff error
        send(1'b1, 1'b0, gap);              // ACK slot
        send(1'b0, 1'b0, gap);              // ACK
        send_run(1'b1, 1'b0, 11, gap);      // eleventh recessive ends the frame
    endtask

    initial begin
        sample_valid = 1'b0; rx_bit = 1'b1; stuff_en = 1'b0;
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Ten recessive bits are not enough; the eleventh declares idle.
        send_run(1'b1, 1'b0, 10, 0);
        check("idle_after_10", bus_idle, 1'b0);
        send(1'b1, 1'b0, 0);
        check("idle_after_11", bus_idle, 1'b1);

        // SOF then 0,0,0,0 then stuff bit 1 then data 1.
        send_run(1'b0, 1'b1, 5, 0);
        send(1'b1, 1'b1, 0);
        check("stuff_removed", stuff_bit, 1'b1);
        send(1'b1, 1'b1, 0);
        check("data_after_stuff", dout, 1'b1);

        // Four more 1s make six in a row -> stuff error, then no SOF accepted.
        send_run(1'b1, 1'b1, 3, 0);
        send(1'b1, 1'b1, 0);
        check("stuff_err_seen", stuff_err, 1'b1);
        send(1'b0, 1'b1, 0);
        check("no_sof_after_err", sof, 1'b0);
        send_run(1'b1, 1'b0, 11, 0);

        // Frame tail dense, then with three idle clocks between samples.
        crc_tail_frame(0);
        crc_tail_frame(3);
        check("idle_after_sparse", bus_idle, 1'b1);

        // Random frames: stuffed region with random bits, then a pass-through tail.
        for (int f = 0; f < 40; f++) begin
            int n_st, n_pt, gap;
            n_st = $urandom_range(40, 5);
            n_pt = $urandom_range(12, 2);
            gap  = $urandom_range(2, 0);
            send(1'b0, 1'b1, gap);
            for (int k = 0; k < n_st; k++) begin
                logic b;
                b = ($urandom_range(5, 0) < 3) ? 1'b1 : 1'b0;
                if ($urandom_range(7, 0) == 0) b = 1'b1;
                send(b, 1'b1, gap);
            end
            for (int k = 0; k < n_pt; k++) send($urandom_range(3, 0) != 0, 1'b0, gap);
            send_run(1'b1, 1'b0, 12, gap);
        end

        // Asynchronous reset mid-frame clears outputs without a clock edge.
        send_run(1'b1, 1'b0, 11, 0);
        send(1'b0, 1'b1, 0);
        send(1'b1, 1'b1, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("async_rst");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        send(1'b0, 1'b1, 0);
        check("no_sof_after_rst", sof, 1'b0);
        send_run(1'b1, 1'b0, 11, 0);
        send(1'b0, 1'b1, 0);
        check("sof_after_idle", sof, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
